// File: rtl/aes_key_sched_ctrl_pkg.sv
// Shared definitions for the AES-128 key schedule controller: sizes, FSM
// encoding, S-box table and GF(2^8) helpers.
package aes_key_sched_ctrl_pkg;

  localparam int AES_KEY_L     = 128;
  localparam int AES_NO_ROUNDS = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } ks_state_e;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_step.sv
// One round of AES-128 key expansion: derives the next round key from the
// current one and the round constant.
module aes_key_expand_step
  import aes_key_sched_ctrl_pkg::*;
(
  input  logic [127:0] key,
  input  logic [7:0]   rcon,
  output logic [127:0] next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w3, sub_w3, temp;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = key[127:96];
  assign w1 = key[95:64];
  assign w2 = key[63:32];
  assign w3 = key[31:0];

  assign rot_w3 = {w3[23:0], w3[31:24]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_subword
      assign sub_w3[8*gi +: 8] = sbox(rot_w3[8*gi +: 8]);
    end
  endgenerate

  assign temp = sub_w3 ^ {rcon, 24'h000000};
  assign n0   = w0 ^ temp;
  assign n1   = w1 ^ n0;
  assign n2   = w2 ^ n1;
  assign n3   = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule controller: expands a cipher key one round per cycle
// into a round-key store that is read back through a registered port.
module aes_key_sched_ctrl
  import aes_key_sched_ctrl_pkg::*;
#(
  parameter int KEY_L     = AES_KEY_L,
  parameter int NO_ROUNDS = AES_NO_ROUNDS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [KEY_L-1:0] cipher_key,
  output logic             busy,
  output logic             done,
  output logic             keys_valid,
  input  logic [3:0]       rk_addr,
  output logic [KEY_L-1:0] rk_data
);

  localparam logic [3:0] LAST_RND = 4'(NO_ROUNDS);

  ks_state_e        state_reg, state_next;
  logic [3:0]       rnd_reg;
  logic [7:0]       rcon_reg;
  logic             done_reg;
  logic             keys_valid_reg;
  logic [KEY_L-1:0] work_key_reg;
  logic [KEY_L-1:0] step_key;
  logic [KEY_L-1:0] rk_data_reg;
  logic [KEY_L-1:0] key_store [0:NO_ROUNDS];

  logic             load_key;
  logic             step_en;
  logic             last_step;
  logic             wr_en;
  logic [3:0]       wr_addr;
  logic [KEY_L-1:0] wr_data;

  aes_key_expand_step u_step (
    .key      (work_key_reg),
    .rcon     (rcon_reg),
    .next_key (step_key)
  );

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // start is only honoured outside EXPAND, so a running expansion never restarts.
  always_comb begin
    state_next = state_reg;
    load_key   = 1'b0;
    step_en    = 1'b0;
    last_step  = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next = ST_EXPAND;
          load_key   = 1'b1;
        end
      end
      ST_EXPAND: begin
        step_en = 1'b1;
        if (rnd_reg == LAST_RND) begin
          last_step  = 1'b1;
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rnd_reg        <= 4'd0;
      rcon_reg       <= 8'h01;
      done_reg       <= 1'b0;
      keys_valid_reg <= 1'b0;
    end else begin
      done_reg <= last_step;
      if (load_key) begin
        rnd_reg        <= 4'd1;
        rcon_reg       <= 8'h01;
        keys_valid_reg <= 1'b0;
      end else if (step_en) begin
        rnd_reg  <= rnd_reg + 4'd1;
        rcon_reg <= xtime(rcon_reg);
        if (last_step) keys_valid_reg <= 1'b1;
      end
    end
  end

  // Single write port shared by the initial key load and every expansion step.
  assign wr_en   = (load_key | step_en) & ~reset;
  assign wr_addr = load_key ? 4'd0 : rnd_reg;
  assign wr_data = load_key ? cipher_key : step_key;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      key_store[wr_addr] <= wr_data;
      work_key_reg       <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                   rk_data_reg <= '0;
    else if (rk_addr > LAST_RND) rk_data_reg <= '0;
    else                         rk_data_reg <= key_store[rk_addr];
  end

  assign busy       = (state_reg == ST_EXPAND);
  assign done       = done_reg;
  assign keys_valid = keys_valid_reg;
  assign rk_data    = rk_data_reg;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: FIPS-197 vectors plus random keys checked
// against a word-level key expansion model built on GF(2^8) arithmetic.
module tb_aes_key_sched_ctrl;

  localparam logic [127:0] FIPS_KEY    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_SLOT1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_SLOT10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_SLOT10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] cipher_key;
  logic         busy, done, keys_valid;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]   model_sbox [0:255];
  logic [127:0] model_rk [0:10];
  logic [127:0] prev_rk [0:10];

  aes_key_sched_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .cipher_key(cipher_key),
    .busy(busy), .done(done), .keys_valid(keys_valid),
    .rk_addr(rk_addr), .rk_data(rk_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] t, s;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
      t = inv;
      s = inv;
      for (int k = 0; k < 4; k++) begin
        t = {t[6:0], t[7]};
        s ^= t;
      end
      model_sbox[v] = s ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {model_sbox[t[31:24]], model_sbox[t[23:16]], model_sbox[t[15:8]], model_sbox[t[7:0]]};
        t ^= {rc, 24'h000000};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Accept one key, then run until keys_valid rises (bounded); optionally
  // toggle start with junk keys while the expansion is in progress.
  task automatic run_expand(input logic [127:0] key, input bit toggle,
                            output int cycles, output int busy_cnt, output int done_cnt);
    cycles = 0; busy_cnt = 0; done_cnt = 0;
    start = 1'b1;
    cipher_key = key;
    tick();
    start = 1'b0;
    if (busy) busy_cnt++;
    while (!keys_valid && cycles < 20) begin
      if (toggle) begin
        start = (cycles % 2 == 0);
        cipher_key = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
      cycles++;
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
    start = 1'b0;
    tick();
    if (done) done_cnt++;
    $display("expand key=%h cycles=%0d busy=%0d done_pulses=%0d", key, cycles, busy_cnt, done_cnt);
  endtask

  task automatic read_slot(input logic [3:0] addr, output logic [127:0] data);
    rk_addr = addr;
    tick();
    data = rk_data;
  endtask

  task automatic check_timing(input string name, input int cycles, input int busy_cnt, input int done_cnt);
    vectors++;
    if (cycles !== 10) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d edges, expected 10", name, cycles);
    end
    vectors++;
    if (busy_cnt !== 10) begin
      miscompares++;
      $display("FAIL %s_busy_cycles: got %0d, expected 10", name, busy_cnt);
    end
    vectors++;
    if (done_cnt !== 1) begin
      miscompares++;
      $display("FAIL %s_done_pulses: got %0d, expected 1", name, done_cnt);
    end
  endtask

  task automatic check_store(input string name);
    logic [127:0] d;
    for (int a = 0; a < 11; a++) begin
      read_slot(4'(a), d);
      vectors++;
      if (d !== model_rk[a]) begin
        miscompares++;
        $display("FAIL %s_slot%0d: got %h expected %h", name, a, d, model_rk[a]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; cipher_key = FIPS_KEY; rk_addr = 4'd0;
    tick(); tick();
    start = 1'b0;
    vectors++;
    if ({busy, done, keys_valid} !== 3'b000 || rk_data !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy/done/kv=%b rk_data=%h expected 000 and 0",
               {busy, done, keys_valid}, rk_data);
    end
    reset = 1'b0;
    tick(); tick();
    vectors++;
    if ({busy, done, keys_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_idle_hold: got busy/done/kv=%b expected 000", {busy, done, keys_valid});
    end
  endtask

  task automatic test_fips_vector();
    int cyc = 0, bc = 0, dc = 0;
    logic [127:0] d;
    start = 1'b1; cipher_key = FIPS_KEY;
    tick();
    start = 1'b0;
    rk_addr = 4'd1;
    tick();
    tick();
    // slot1 was written on edge 2, so the read registered on edge 3 sees it.
    vectors++;
    if (rk_data !== FIPS_SLOT1 || busy !== 1'b1 || keys_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL fips_slot1_early: got %h busy=%b kv=%b expected %h busy=1 kv=0",
               rk_data, busy, keys_valid, FIPS_SLOT1);
    end
    while (!keys_valid && cyc < 20) begin
      tick();
      cyc++;
      if (done) dc++;
    end
    vectors++;
    if (cyc !== 8 || dc !== 1) begin
      miscompares++;
      $display("FAIL fips_done_edge: got %0d more edges, %0d pulses, expected 8 and 1", cyc, dc);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || keys_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL fips_done_one_cycle: got done=%b kv=%b expected 0 1", done, keys_valid);
    end
    read_slot(4'd10, d);
    vectors++;
    if (d !== FIPS_SLOT10) begin
      miscompares++;
      $display("FAIL fips_slot10: got %h expected %h", d, FIPS_SLOT10);
    end
    model_expand(FIPS_KEY);
    check_store("fips");
  endtask

  task automatic test_zero_key();
    int cyc, bc, dc;
    logic [127:0] d;
    run_expand('0, 1'b0, cyc, bc, dc);
    check_timing("zero", cyc, bc, dc);
    read_slot(4'd10, d);
    vectors++;
    if (d !== ZERO_SLOT10) begin
      miscompares++;
      $display("FAIL zero_slot10: got %h expected %h", d, ZERO_SLOT10);
    end
  endtask

  task automatic test_start_ignored();
    int cyc, bc, dc;
    run_expand(FIPS_KEY, 1'b1, cyc, bc, dc);
    check_timing("toggle", cyc, bc, dc);
    model_expand(FIPS_KEY);
    check_store("toggle");
  endtask

  task automatic test_reset_mid_expand();
    int dc = 0;
    logic [127:0] d;
    logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
    for (int r = 0; r < 11; r++) prev_rk[r] = model_rk[r];
    start = 1'b1; cipher_key = k;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if ({busy, done, keys_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL abort_state: got busy/done/kv=%b expected 000", {busy, done, keys_valid});
    end
    for (int c = 0; c < 14; c++) begin
      tick();
      if (done || busy || keys_valid) dc++;
    end
    vectors++;
    if (dc !== 0) begin
      miscompares++;
      $display("FAIL abort_quiet: got %0d active cycles expected 0", dc);
    end
    // slot4 would have been written on edge 5; it must still hold the old key.
    read_slot(4'd4, d);
    vectors++;
    if (d !== prev_rk[4]) begin
      miscompares++;
      $display("FAIL abort_no_write: got %h expected %h", d, prev_rk[4]);
    end
    begin
      int cyc, bc, dc2;
      run_expand(FIPS_KEY, 1'b0, cyc, bc, dc2);
      check_timing("after_abort", cyc, bc, dc2);
    end
    model_expand(FIPS_KEY);
    check_store("after_abort");
  endtask

  task automatic test_restart_in_done();
    int cyc = 0, dc = 0;
    logic [127:0] d;
    rk_addr = 4'd0;
    start = 1'b1; cipher_key = '0;
    tick();
    start = 1'b0;
    vectors++;
    if (keys_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_flags: got kv=%b done=%b busy=%b expected 0 0 1", keys_valid, done, busy);
    end
    // Same-edge read of slot0 returns the contents before the new key landed.
    vectors++;
    if (rk_data !== FIPS_KEY) begin
      miscompares++;
      $display("FAIL restart_prewrite_read: got %h expected %h", rk_data, FIPS_KEY);
    end
    while (!keys_valid && cyc < 20) begin
      tick();
      cyc++;
      if (done) dc++;
    end
    vectors++;
    if (cyc !== 10 || dc !== 1) begin
      miscompares++;
      $display("FAIL restart_latency: got %0d edges %0d pulses expected 10 and 1", cyc, dc);
    end
    read_slot(4'd10, d);
    vectors++;
    if (d !== ZERO_SLOT10) begin
      miscompares++;
      $display("FAIL restart_slot10: got %h expected %h", d, ZERO_SLOT10);
    end
    model_expand('0);
  endtask

  task automatic test_read_sweep();
    logic [127:0] exp_d;
    for (int a = 0; a < 16; a++) begin
      rk_addr = 4'(a);
      tick();
      exp_d = (a <= 10) ? model_rk[a] : '0;
      vectors++;
      if (rk_data !== exp_d) begin
        miscompares++;
        $display("FAIL sweep_addr%0d: got %h expected %h", a, rk_data, exp_d);
      end
    end
    vectors++;
    if (keys_valid !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL done_persist: got kv=%b done=%b busy=%b expected 1 0 0", keys_valid, done, busy);
    end
  endtask

  task automatic test_random_keys();
    for (int n = 0; n < 4; n++) begin
      int cyc, bc, dc;
      logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
      run_expand(k, 1'b0, cyc, bc, dc);
      check_timing("random", cyc, bc, dc);
      model_expand(k);
      check_store("random");
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cipher_key = '0; rk_addr = 4'd0;
    build_sbox();
    test_reset();
    test_fips_vector();
    test_zero_key();
    test_start_ignored();
    test_random_keys();
    test_reset_mid_expand();
    test_restart_in_done();
    test_read_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
